// File: rtl/grn_lut_node.sv
// Boolean gene-regulatory-network node with a run-time loadable K-input truth table.
// Holds a slow (divided) and a fast copy of the gene state and counts fast-copy toggles.
module grn_lut_node #(
  parameter int K        = 4,
  parameter int SLOW_DIV = 2,
  parameter int CNT_W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reset_nos,
  input  logic            init_state,
  input  logic            start_s0,
  input  logic            start_s1,
  input  logic [K-1:0]    nb_s0,
  input  logic [K-1:0]    nb_s1,
  input  logic            cfg_we,
  input  logic [2**K-1:0] cfg_lut,
  output logic            s0,
  output logic            s1,
  output logic            gp_s0,
  output logic            gp_s1,
  output logic            match,
  output logic [CNT_W-1:0] flip_cnt
);

  localparam int DIV_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(SLOW_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [2**K-1:0]  lut_q, lut_d;
  logic             s0_q, s0_d;
  logic             s1_q, s1_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] flip_cnt_q, flip_cnt_d;

  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latches).
    lut_d      = lut_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    div_cnt_d  = div_cnt_q;
    flip_cnt_d = flip_cnt_q;

    // Table writes land at the edge; strobes this cycle still read lut_q (old table).
    if (cfg_we) lut_d = cfg_lut;

    if (reset_nos) begin
      s0_d       = init_state;
      s1_d       = init_state;
      div_cnt_d  = '0;
      flip_cnt_d = '0;
    end else begin
      if (start_s0) begin
        if (div_cnt_q == '0) begin
          s0_d      = lut_q[nb_s0];
          div_cnt_d = DIV_RELOAD;
        end else begin
          div_cnt_d = div_cnt_q - 1'b1;
        end
      end
      if (start_s1) begin
        s1_d = lut_q[nb_s1];
        if ((s1_d != s1_q) && (flip_cnt_q != CNT_MAX)) flip_cnt_d = flip_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      lut_q      <= '0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      div_cnt_q  <= '0;
      flip_cnt_q <= '0;
    end else begin
      lut_q      <= lut_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      div_cnt_q  <= div_cnt_d;
      flip_cnt_q <= flip_cnt_d;
    end
  end

  assign s0       = s0_q;
  assign s1       = s1_q;
  assign gp_s0    = s0_q;
  assign gp_s1    = s1_q;
  assign match    = (s0_q == s1_q);
  assign flip_cnt = flip_cnt_q;

endmodule

// File: tb/tb_grn_lut_node.sv
// Scoreboard bench for grn_lut_node: each driven cycle pushes the expected outputs,
// which are popped and compared one clock later.
module tb_grn_lut_node;

  localparam int K        = 4;
  localparam int SLOW_DIV = 2;
  localparam int CNT_W    = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            reset_nos = 1'b0;
  logic            init_state = 1'b0;
  logic            start_s0 = 1'b0;
  logic            start_s1 = 1'b0;
  logic [K-1:0]    nb_s0 = '0;
  logic [K-1:0]    nb_s1 = '0;
  logic            cfg_we = 1'b0;
  logic [2**K-1:0] cfg_lut = '0;
  logic            s0, s1, gp_s0, gp_s1, match;
  logic [CNT_W-1:0] flip_cnt;

  grn_lut_node #(.K(K), .SLOW_DIV(SLOW_DIV), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state),
    .start_s0(start_s0), .start_s1(start_s1), .nb_s0(nb_s0), .nb_s1(nb_s1),
    .cfg_we(cfg_we), .cfg_lut(cfg_lut), .s0(s0), .s1(s1), .gp_s0(gp_s0), .gp_s1(gp_s1),
    .match(match), .flip_cnt(flip_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic             s0;
    logic             s1;
    logic [CNT_W-1:0] flip;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  // Reference model state, advanced by the bench as it drives each cycle.
  logic [2**K-1:0]  m_lut = '0;
  logic             m_s0 = 1'b0;
  logic             m_s1 = 1'b0;
  int               m_div = 0;
  int               m_flip = 0;

  task automatic model_cycle(input logic r, input logic rn, input logic init, input logic st0,
                             input logic st1, input logic [K-1:0] n0, input logic [K-1:0] n1,
                             input logic we, input logic [2**K-1:0] lut_in);
    logic [2**K-1:0] next_lut;
    logic            nv;
    if (r) begin
      m_lut = '0; m_s0 = 1'b0; m_s1 = 1'b0; m_div = 0; m_flip = 0;
      return;
    end
    next_lut = we ? lut_in : m_lut;
    if (rn) begin
      m_s0 = init; m_s1 = init; m_div = 0; m_flip = 0;
    end else begin
      if (st0) begin
        if (m_div == 0) begin
          m_s0  = m_lut[n0];
          m_div = SLOW_DIV - 1;
        end else begin
          m_div = m_div - 1;
        end
      end
      if (st1) begin
        nv = m_lut[n1];
        if (nv != m_s1 && m_flip < (2**CNT_W - 1)) m_flip = m_flip + 1;
        m_s1 = nv;
      end
    end
    m_lut = next_lut;
  endtask

  // Drive one cycle at negedge, push the expectation, compare it after the next rising edge.
  task automatic step(input string name, input logic r, input logic rn, input logic init,
                      input logic st0, input logic st1, input logic [K-1:0] n0,
                      input logic [K-1:0] n1, input logic we, input logic [2**K-1:0] lut_in);
    exp_t e;
    @(negedge clk);
    rst = r; reset_nos = rn; init_state = init; start_s0 = st0; start_s1 = st1;
    nb_s0 = n0; nb_s1 = n1; cfg_we = we; cfg_lut = lut_in;
    model_cycle(r, rn, init, st0, st1, n0, n1, we, lut_in);
    sb.push_back('{name: name, s0: m_s0, s1: m_s1, flip: CNT_W'(m_flip)});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    tests_run++;
    if (s0 !== e.s0 || gp_s0 !== e.s0) begin
      tests_failed++;
      $display("FAIL %s s0: got s0=%b gp_s0=%b expected %b", e.name, s0, gp_s0, e.s0);
    end
    tests_run++;
    if (s1 !== e.s1 || gp_s1 !== e.s1) begin
      tests_failed++;
      $display("FAIL %s s1: got s1=%b gp_s1=%b expected %b", e.name, s1, gp_s1, e.s1);
    end
    tests_run++;
    if (match !== (e.s0 == e.s1)) begin
      tests_failed++;
      $display("FAIL %s match: got %b expected %b", e.name, match, (e.s0 == e.s1));
    end
    tests_run++;
    if (flip_cnt !== e.flip) begin
      tests_failed++;
      $display("FAIL %s flip_cnt: got %0d expected %0d", e.name, flip_cnt, e.flip);
    end
    rst = 1'b0; reset_nos = 1'b0; start_s0 = 1'b0; start_s1 = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    step("rst_a", 1, 0, 0, 0, 0, 4'h0, 4'h0, 0, 16'h0000);
    step("load_ffff", 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 16'hFFFF);
    step("rst_b", 1, 0, 0, 0, 0, 4'h0, 4'h0, 0, 16'h0000);
    tests_run++;
    if (s0 !== 1'b0 || s1 !== 1'b0 || flip_cnt !== 8'd0 || match !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_state: got s0=%b s1=%b flip=%0d match=%b expected 0 0 0 1",
               s0, s1, flip_cnt, match);
    end
    // The table was cleared by rst, so any index reads 0.
    step("s1_after_rst", 0, 0, 0, 0, 1, 4'h0, 4'h9, 0, 16'h0000);
    tests_run++;
    if (s1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL lut_cleared: got s1=%b expected 0", s1);
    end
  endtask

  task automatic test_and_table();
    step("load_and", 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 16'h8000);
    step("nos_init0", 0, 1, 0, 0, 0, 4'h0, 4'h0, 0, 16'h0000);
    step("and_F", 0, 0, 0, 0, 1, 4'h0, 4'hF, 0, 16'h0000);
    step("and_7", 0, 0, 0, 0, 1, 4'h0, 4'h7, 0, 16'h0000);
    tests_run++;
    if (s1 !== 1'b0 || flip_cnt !== 8'd2) begin
      tests_failed++;
      $display("FAIL and_table: got s1=%b flip=%0d expected s1=0 flip=2", s1, flip_cnt);
    end
    // Both copies in the same cycle with different regulator patterns.
    step("both_strobe", 0, 0, 0, 1, 1, 4'hF, 4'hE, 0, 16'h0000);
  endtask

  task automatic test_slow_div();
    step("load_ones", 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 16'hFFFF);
    step("nos_div", 0, 1, 0, 0, 0, 4'h0, 4'h0, 0, 16'h0000);
    step("s0_strobe1", 0, 0, 0, 1, 0, 4'h3, 4'h0, 0, 16'h0000);
    step("s0_strobe2", 0, 0, 0, 1, 0, 4'h3, 4'h0, 0, 16'h0000);
    step("load_zero", 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 16'h0000);
    step("s0_strobe3", 0, 0, 0, 1, 0, 4'h3, 4'h0, 0, 16'h0000);
    tests_run++;
    if (s0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL div_update3: got s0=%b expected 0", s0);
    end
    step("load_ones2", 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 16'hFFFF);
    step("s0_strobe4", 0, 0, 0, 1, 0, 4'h3, 4'h0, 0, 16'h0000);
    step("s0_strobe5", 0, 0, 0, 1, 0, 4'h3, 4'h0, 0, 16'h0000);
  endtask

  task automatic test_cfg_same_cycle();
    step("load_ones3", 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 16'hFFFF);
    step("nos_init1", 0, 1, 1, 0, 0, 4'h0, 4'h0, 0, 16'h0000);
    step("old_lut", 0, 0, 0, 0, 1, 4'h0, 4'h5, 1, 16'h0000);
    tests_run++;
    if (s1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL old_lut_used: got s1=%b expected 1", s1);
    end
    step("new_lut", 0, 0, 0, 0, 1, 4'h0, 4'h5, 0, 16'h0000);
  endtask

  task automatic test_saturation();
    step("load_toggle", 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 16'h5555);
    step("nos_sat", 0, 1, 0, 0, 0, 4'h0, 4'h0, 0, 16'h0000);
    for (int i = 0; i < 300; i++)
      step("toggle", 0, 0, 0, 0, 1, 4'h0, {3'b000, m_s1}, 0, 16'h0000);
    tests_run++;
    if (flip_cnt !== 8'd255) begin
      tests_failed++;
      $display("FAIL saturate: got flip=%0d expected 255", flip_cnt);
    end
    step("nos_clear", 0, 1, 0, 0, 0, 4'h0, 4'h0, 0, 16'h0000);
  endtask

  task automatic test_priority();
    step("load_zero2", 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 16'h0000);
    step("nos_vs_strobe", 0, 1, 1, 1, 1, 4'h2, 4'h2, 0, 16'h0000);
    tests_run++;
    if (s0 !== 1'b1 || s1 !== 1'b1 || flip_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL nos_priority: got s0=%b s1=%b flip=%0d expected 1 1 0", s0, s1, flip_cnt);
    end
    step("idle_hold", 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 16'h0000);
    step("rst_mid", 1, 1, 1, 1, 1, 4'h0, 4'h0, 1, 16'hFFFF);
    tests_run++;
    if (s0 !== 1'b0 || s1 !== 1'b0 || flip_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL rst_priority: got s0=%b s1=%b flip=%0d expected 0 0 0", s0, s1, flip_cnt);
    end
    step("after_rst", 0, 0, 0, 1, 1, 4'hF, 4'hF, 0, 16'h0000);
  endtask

  initial begin
    test_reset();
    test_and_table();
    test_slow_div();
    test_cfg_same_cycle();
    test_saturation();
    test_priority();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
